// File: rtl/prim_clock_div_prog.sv
// Programmable glitch-free integer clock divider with a req/ack ratio-change
// handshake and a run/stop enable that only takes effect on whole periods.
//
// state  | meaning
// StIdle | clk_q held low, cnt held at 0; divisor loads and run requests are taken at once
// StRun  | clk_q follows the period pattern; changes are taken only when cnt == div_q-1
module prim_clock_div_prog #(
  parameter int unsigned DivW        = 8,
  parameter int unsigned DefaultDiv  = 4,
  parameter bit          HasScanMode = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            scanmode_i,
  input  logic            en_i,
  input  logic            div_req_i,
  input  logic [DivW-1:0] div_i,
  output logic            div_ack_o,
  output logic [DivW-1:0] div_o,
  output logic            active_o,
  output logic            clk_o
);

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [DivW-1:0] MinDiv = DivW'(2);

  state_e          state;
  logic [DivW-1:0] cnt;
  logic [DivW-1:0] div_q;
  logic            clk_q;
  logic            ack_q;

  logic [DivW-1:0] div_sat;
  logic [DivW-1:0] cnt_inc;
  logic [DivW-1:0] hi_len;
  logic            at_bound;

  // Divisors below 2 cannot produce a two-phase clock, so they load as 2.
  assign div_sat  = (div_i < MinDiv) ? MinDiv : div_i;
  assign cnt_inc  = cnt + 1'b1;
  assign hi_len   = div_q >> 1;
  assign at_bound = (cnt == (div_q - 1'b1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= StIdle;
      cnt   <= '0;
      div_q <= DivW'(DefaultDiv);
      clk_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        StIdle: begin
          cnt   <= '0;
          clk_q <= 1'b0;
          if (div_req_i) begin
            div_q <= div_sat;
            ack_q <= 1'b1;
          end
          if (en_i) begin
            state <= StRun;
            clk_q <= 1'b1;
          end
        end
        StRun: begin
          if (at_bound) begin
            cnt <= '0;
            if (div_req_i) begin
              div_q <= div_sat;
              ack_q <= 1'b1;
            end
            if (!en_i) begin
              state <= StIdle;
              clk_q <= 1'b0;
            end else begin
              clk_q <= 1'b1;
            end
          end else begin
            cnt   <= cnt_inc;
            clk_q <= (cnt_inc < hi_len);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Same select as prim_generic_clock_mux2: clk0 = clk_q, clk1 = clk_i.
  assign clk_o     = (HasScanMode && scanmode_i) ? clk_i : clk_q;
  assign div_ack_o = ack_q;
  assign div_o     = div_q;
  assign active_o  = (state == StRun);

endmodule

// File: tb/tb_prim_clock_div_prog.sv
// Self-checking bench for prim_clock_div_prog: directed scenarios plus random
// enable/request traffic against a period-level reference model.
module tb_prim_clock_div_prog;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       scanmode_i = 1'b0;
  logic       en_i = 1'b0;
  logic       div_req_i = 1'b0;
  logic [7:0] div_i = 8'd0;
  logic       div_ack_o;
  logic [7:0] div_o;
  logic       active_o;
  logic       clk_o;

  prim_clock_div_prog #(
    .DivW(8),
    .DefaultDiv(4),
    .HasScanMode(1'b1)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .scanmode_i(scanmode_i),
    .en_i(en_i),
    .div_req_i(div_req_i),
    .div_i(div_i),
    .div_ack_o(div_ack_o),
    .div_o(div_o),
    .active_o(active_o),
    .clk_o(clk_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err = 0;

  // Reference: running flag, position within the current period, divisor, ack.
  bit m_run;
  int m_pos;
  int m_div;
  bit m_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  function automatic void model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_div = 4;
    m_ack = 1'b0;
  endfunction

  // Clock is high for the first div/2 positions of each period.
  function automatic logic exp_clk();
    return m_run && (m_pos < m_div / 2);
  endfunction

  function automatic void model_step();
    bit bnd;
    bnd   = !m_run || (m_pos == m_div - 1);
    m_ack = 1'b0;
    if (bnd) begin
      if (div_req_i) begin
        m_div = sat(int'(div_i));
        m_ack = 1'b1;
      end
      if (!m_run) begin
        if (en_i) begin
          m_run = 1'b1;
          m_pos = 0;
        end
      end else begin
        m_pos = 0;
        if (!en_i) m_run = 1'b0;
      end
    end else begin
      m_pos++;
    end
  endfunction

  // One clk_i cycle: check at the falling edge, let the requester drop its
  // request on ack, then advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk_i);
    check("clk_o", clk_o, scanmode_i ? 1'b0 : exp_clk());
    check("active", active_o, m_run);
    check("div_o", div_o, m_div);
    check("ack", div_ack_o, m_ack);
    if (div_req_i && div_ack_o) div_req_i = 1'b0;
    @(posedge clk_i);
    if (rst_ni) model_step();
    #1;
    if (scanmode_i) check("scan_hi", clk_o, 1'b1);
  endtask

  task automatic request(input logic [7:0] d);
    int n;
    n = 0;
    div_i = d;
    div_req_i = 1'b1;
    while (div_req_i && n < 600) begin
      cycle();
      n++;
    end
    check("ack_within_bound", (n < 600), 1'b1);
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (!(m_run && m_pos == p) && n < 600) begin
      cycle();
      n++;
    end
    check("pos_within_bound", (n < 600), 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_clk", clk_o, 1'b0);
    check("rst_div", div_o, 8'd4);
    check("rst_active", active_o, 1'b0);
    check("rst_ack", div_ack_o, 1'b0);
    rst_ni = 1'b1;

    // Default ratio 4
    repeat (2) cycle();
    en_i = 1'b1;
    repeat (10) cycle();

    // Change to 5 requested mid-period
    wait_pos(1);
    request(8'd5);
    repeat (12) cycle();

    // Saturation of 0 and 1
    request(8'd0);
    check("sat0", div_o, 8'd2);
    repeat (6) cycle();
    request(8'd1);
    check("sat1", div_o, 8'd2);
    repeat (6) cycle();

    // Stop mid-period at ratio 6, then restart
    request(8'd6);
    repeat (7) cycle();
    wait_pos(1);
    en_i = 1'b0;
    repeat (8) cycle();
    check("stopped", active_o, 1'b0);
    en_i = 1'b1;
    repeat (8) cycle();

    // Enable and request together from IDLE
    en_i = 1'b0;
    repeat (10) cycle();
    en_i = 1'b1;
    div_i = 8'd3;
    div_req_i = 1'b1;
    repeat (9) cycle();
    check("idle_combo_div", div_o, 8'd3);

    // Scan bypass
    scanmode_i = 1'b1;
    repeat (6) cycle();
    scanmode_i = 1'b0;
    repeat (3) cycle();

    // Reset during the high phase with a request pending
    wait_pos(0);
    check("pre_rst_hi", clk_o, 1'b1);
    div_i = 8'd9;
    div_req_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_clk", clk_o, 1'b0);
    check("rst_async_active", active_o, 1'b0);
    model_reset();
    div_req_i = 1'b0;
    en_i = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (6) cycle();
    check("no_ack_after_rst", div_o, 8'd4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 12 == 0) en_i = ~en_i;
      if (!div_req_i && ($urandom % 10 == 0)) begin
        if ($urandom % 6 == 0) div_i = 8'($urandom);
        else div_i = 8'($urandom % 10);
        div_req_i = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
